// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - inter-stage pipeline register with valid/ready handshake and 2-entry skid buffer
//
// Purpose:
//   Holds one live beat in the main entry (drives the outputs) and can absorb one
//   more beat in the skid entry, so in_ready depends only on registered state and
//   never on out_ready. Bubbles (ctrl = 0) are presented on reset, flush and when empty.
//
// Ports:
//   clk        in   1       clock, rising edge
//   rst        in   1       synchronous active-high reset
//   flush      in   1       synchronous kill of all held entries
//   in_valid   in   1       upstream beat valid
//   in_ready   out  1       stage can accept a beat this cycle
//   in_ctrl    in   CTRL_W  upstream control bundle
//   in_data    in   DATA_W  upstream payload
//   out_valid  out  1       outputs hold a live beat
//   out_ready  in   1       downstream accepts this cycle
//   out_ctrl   out  CTRL_W  control to next stage, 0 when out_valid = 0
//   out_data   out  DATA_W  payload to next stage
module pipe_stage_skid #(
    parameter int CTRL_W     = 3,
    parameter int DATA_W     = 101,
    parameter bit CLEAR_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
);

    // Occupancy: ONE means only the main entry is live, FULL means both are.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [CTRL_W-1:0] m_ctrl;
    logic [DATA_W-1:0] m_data;
    logic [CTRL_W-1:0] s_ctrl;
    logic [DATA_W-1:0] s_data;

    logic m_valid;
    logic s_valid;
    logic accept;
    logic drain;
    logic load_m_in;
    logic load_m_s;
    logic load_s_in;

    assign m_valid = (state_q == ONE) || (state_q == FULL);
    assign s_valid = (state_q == FULL);

    // Registered-only ready: the rst term just blocks acceptance during reset.
    assign in_ready = !s_valid && !rst;
    assign accept   = in_valid && in_ready;
    assign drain    = m_valid && out_ready;

    assign out_valid = m_valid;
    assign out_ctrl  = m_valid ? m_ctrl : '0;
    assign out_data  = m_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load_m_in = 1'b0;
        load_m_s  = 1'b0;
        load_s_in = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d   = ONE;
                    load_m_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    load_m_in = 1'b1;
                end else if (accept) begin
                    state_d   = FULL;
                    load_s_in = 1'b1;
                end else if (drain) begin
                    state_d   = EMPTY;
                end
            end
            FULL: begin
                if (drain) begin
                    state_d  = ONE;
                    load_m_s = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        // A beat offered during flush is discarded; a same-cycle drain still
        // completes downstream because outputs are unaffected until the edge.
        if (flush) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_ctrl <= '0;
            m_data <= '0;
            s_ctrl <= '0;
            s_data <= '0;
        end else if (flush) begin
            m_ctrl <= '0;
            s_ctrl <= '0;
            if (CLEAR_DATA) begin
                m_data <= '0;
                s_data <= '0;
            end
        end else begin
            if (load_m_in) begin
                m_ctrl <= in_ctrl;
                m_data <= in_data;
            end else if (load_m_s) begin
                m_ctrl <= s_ctrl;
                m_data <= s_data;
            end
            if (load_s_in) begin
                s_ctrl <= in_ctrl;
                s_data <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - scoreboard bench for pipe_stage_skid with both CLEAR_DATA settings
module tb_pipe_stage_skid;

    localparam int CTRL_W = 3;
    localparam int DATA_W = 101;

    typedef struct {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_ready;

    logic              r0, v0, r1, v1;
    logic [CTRL_W-1:0] c0, c1;
    logic [DATA_W-1:0] d0, d1;

    int checks = 0;
    int errors = 0;

    beat_t q[$];

    always #5 clk = ~clk;

    pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(r0), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(v0), .out_ready(out_ready), .out_ctrl(c0), .out_data(d0)
    );

    pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(1'b1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(r1), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(v1), .out_ready(out_ready), .out_ctrl(c1), .out_data(d1)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_dut(input string tag, input logic rdy, input logic vld,
                           input logic [CTRL_W-1:0] ctl, input logic [DATA_W-1:0] dat,
                           input logic e_rdy, input logic e_vld,
                           input logic [CTRL_W-1:0] e_ctl, input logic [DATA_W-1:0] e_dat);
        chk({tag, ".in_ready"}, 128'(rdy), 128'(e_rdy));
        chk({tag, ".out_valid"}, 128'(vld), 128'(e_vld));
        chk({tag, ".out_ctrl"}, 128'(ctl), 128'(e_ctl));
        if (e_vld) chk({tag, ".out_data"}, 128'(dat), 128'(e_dat));
    endtask

    // Reference model: the stage is a FIFO of capacity two. Outputs are checked
    // mid-cycle; the queue is then advanced by what the coming edge will do.
    always @(negedge clk) begin
        logic              e_rdy, e_vld;
        logic [CTRL_W-1:0] e_ctl;
        logic [DATA_W-1:0] e_dat;
        beat_t             b;
        e_rdy = !rst && (q.size() < 2);
        e_vld = (q.size() > 0);
        e_ctl = e_vld ? q[0].ctrl : '0;
        e_dat = e_vld ? q[0].data : '0;
        chk_dut("clr0", r0, v0, c0, d0, e_rdy, e_vld, e_ctl, e_dat);
        chk_dut("clr1", r1, v1, c1, d1, e_rdy, e_vld, e_ctl, e_dat);
        if (rst) begin
            q.delete();
        end else begin
            if (e_vld && out_ready) void'(q.pop_front());
            if (flush) begin
                q.delete();
            end else if (in_valid && e_rdy) begin
                b.ctrl = in_ctrl;
                b.data = in_data;
                q.push_back(b);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                         input logic r, input logic f);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = r;
        flush     = f;
    endtask

    initial begin
        logic [127:0] rnd;
        logic [DATA_W-1:0] hold_d;

        // Reset with an offered beat
        rst = 1'b1;
        drive(1'b1, 3'b111, 101'h5A, 1'b1, 1'b0);
        step();
        step();
        chk("rst.out_data0", 128'(d0), 128'h0);
        chk("rst.out_data1", 128'(d1), 128'h0);
        chk("rst.in_ready", 128'(r0), 128'h0);
        rst = 1'b0;
        drive(1'b0, 3'b000, '0, 1'b1, 1'b0);
        #1;
        chk("post_rst.in_ready", 128'(r0), 128'h1);
        step();

        // Streaming
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 3'b101, DATA_W'(i), 1'b1, 1'b0);
            step();
        end
        drive(1'b0, 3'b000, '0, 1'b1, 1'b0);
        step();
        step();
        chk("stream.drained", 128'(q.size()), 128'h0);

        // Skid: A, B absorbed while stalled, C held off then accepted
        drive(1'b1, 3'b001, 101'hA, 1'b0, 1'b0); step();
        drive(1'b1, 3'b010, 101'hB, 1'b0, 1'b0); step();
        drive(1'b1, 3'b011, 101'hC, 1'b0, 1'b0);
        chk("skid.full_ready", 128'(r0), 128'h0);
        step();
        drive(1'b1, 3'b011, 101'hC, 1'b1, 1'b0); step();
        drive(1'b1, 3'b011, 101'hC, 1'b1, 1'b0); step();
        drive(1'b0, 3'b000, '0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step();
        chk("skid.drained", 128'(q.size()), 128'h0);

        // Flush from FULL with a same-cycle offered beat
        drive(1'b1, 3'b110, 101'h11, 1'b0, 1'b0); step();
        drive(1'b1, 3'b110, 101'h22, 1'b0, 1'b0); step();
        drive(1'b1, 3'b110, 101'h33, 1'b0, 1'b1); step();
        drive(1'b0, 3'b000, '0, 1'b1, 1'b0);
        chk("flush.out_valid", 128'(v0), 128'h0);
        chk("flush.out_ctrl", 128'(c0), 128'h0);
        chk("flush.in_ready", 128'(r0), 128'h1);
        chk("flush.held_data", 128'(d0), 128'h11);
        chk("flush.cleared_data", 128'(d1), 128'h0);
        for (int i = 0; i < 3; i++) step();

        // Stall hold
        hold_d = 101'h1_2345_6789_ABCD;
        drive(1'b1, 3'b100, hold_d, 1'b0, 1'b0); step();
        drive(1'b0, 3'b000, '0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("stall.ctrl", 128'(c0), 128'(3'b100));
            chk("stall.data", 128'(d0), 128'(hold_d));
            step();
        end
        out_ready = 1'b1;
        step();
        step();

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 10000; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            rst = ($urandom_range(999) < 5);
            drive($urandom_range(99) < 70, CTRL_W'($urandom), rnd[DATA_W-1:0],
                  $urandom_range(99) < 60, $urandom_range(99) < 2);
            step();
        end
        rst = 1'b0;
        drive(1'b0, 3'b000, '0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step();
        chk("random.drained", 128'(q.size()), 128'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
